// File: rtl/chdr_8s_to_16s.sv
// rtl/chdr_8s_to_16s.sv - CHDR sc8 -> sc16 payload expander with length rewrite, zero latency.
// Optional SID destination override compiled in with CHDR_8S_TO_16S_SID_OVERRIDE_EN.
module chdr_8s_to_16s #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data
);

  typedef enum logic [1:0] {ST_HEADER, ST_TIME, ST_HIGH, ST_LOW} state_e;

  state_e      state_q, state_d;
  logic        half_last_q, half_last_d;
  logic        has_time;
  logic [15:0] hdr_bytes;
  logic [15:0] payload_len;
  logic [15:0] new_len;
  logic        single;
  logic        o_hs;
  logic [31:0] sid_word;

  function automatic logic [63:0] expand(input logic [31:0] s);
    return {s[31:24], 8'h00, s[23:16], 8'h00, s[15:8], 8'h00, s[7:0], 8'h00};
  endfunction

  assign has_time    = i_tdata[61];
  assign hdr_bytes   = has_time ? 16'd16 : 16'd8;
  assign payload_len = i_tdata[47:32] - hdr_bytes;
  assign new_len     = {payload_len[14:0], 1'b0} + hdr_bytes;
  assign single      = i_tlast && half_last_q;
  // o_tvalid always mirrors i_tvalid; use the input directly to keep the comb graph acyclic
  assign o_hs        = i_tvalid && o_tready;

`ifdef CHDR_8S_TO_16S_SID_OVERRIDE_EN
  logic [16:0] sid_reg_q;
  logic        unused_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_reg_q <= '0;
    end else if (set_stb && (set_addr == BASE)) begin
      sid_reg_q <= set_data[16:0];
    end
  end

  assign sid_word   = sid_reg_q[16] ? {i_tdata[15:0], sid_reg_q[15:0]} : i_tdata[31:0];
  assign unused_set = ^set_data[31:17];
`else
  logic unused_set;
  assign unused_set = ^{set_stb, set_addr, set_data, BASE};
  assign sid_word   = i_tdata[31:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HEADER;
      half_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_last_q <= half_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_last_d = half_last_q;
    o_tdata     = i_tdata;
    o_tlast     = i_tlast;
    o_tvalid    = i_tvalid;
    i_tready    = o_tready;
    case (state_q)
      ST_HEADER: begin
        o_tdata = {i_tdata[63:48], new_len, sid_word};
        if (o_hs) begin
          half_last_d = (payload_len[2:0] != 3'd0) && (payload_len[2:0] <= 3'd4);
          if (!i_tlast) begin
            state_d = has_time ? ST_TIME : ST_HIGH;
          end
        end
      end
      ST_TIME: begin
        if (o_hs) begin
          state_d = i_tlast ? ST_HEADER : ST_HIGH;
        end
      end
      ST_HIGH: begin
        // Input word is held upstream unless this is a half-filled final beat
        o_tdata  = expand(i_tdata[63:32]);
        o_tlast  = single;
        i_tready = single ? o_tready : 1'b0;
        if (o_hs) begin
          state_d = single ? ST_HEADER : ST_LOW;
        end
      end
      ST_LOW: begin
        o_tdata = expand(i_tdata[31:0]);
        if (o_hs) begin
          state_d = i_tlast ? ST_HEADER : ST_HIGH;
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

endmodule

// File: tb/tb_chdr_8s_to_16s.sv
// tb/tb_chdr_8s_to_16s.sv - directed vector table plus throttled random-packet scoreboard.
module tb_chdr_8s_to_16s;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  always #5 clk = ~clk;

  chdr_8s_to_16s #(.BASE(8'd0)) dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data)
  );

  typedef struct {
    logic        r;
    logic [63:0] d;
    logic        l, v, ordy;
    logic [63:0] ed;
    logic        el, ev, er;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  vec_t  vecs[$];
  beat_t inq[$];
  beat_t expq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [63:0] exp16(input logic [31:0] s);
    logic [63:0] o;
    for (int k = 0; k < 4; k++) o[63-16*k -: 16] = {s[31-8*k -: 8], 8'h00};
    return o;
  endfunction

  function automatic void add(input logic r, input logic [63:0] d, input logic l, v, ordy,
                              input logic [63:0] ed, input logic el, ev, er);
    vec_t x;
    x.r = r; x.d = d; x.l = l; x.v = v; x.ordy = ordy;
    x.ed = ed; x.el = el; x.ev = ev; x.er = er;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  logic        ht, in_hs;
  int          pb, hb, nw, idx, cyc;
  logic [63:0] h, w;
  logic [15:0] nl;
  beat_t       b, e;

  initial begin
    rst = 1'b1; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    set_stb = 1'b0; set_addr = '0; set_data = '0;

    add(1, 64'h0, 0, 0, 1, 64'h0000_FFF8_0000_0000, 0, 0, 1);
    add(1, 64'h0, 0, 1, 0, 64'h0000_FFF8_0000_0000, 0, 1, 0);
    add(0, 64'h0000_0010_0000_1234, 0, 1, 1, 64'h0000_0018_0000_1234, 0, 1, 1);
    add(0, 64'h0102_0304_0506_0708, 1, 1, 1, 64'h0100_0200_0300_0400, 0, 1, 0);
    add(0, 64'h0102_0304_0506_0708, 1, 1, 1, 64'h0500_0600_0700_0800, 1, 1, 1);
    add(0, 64'h2000_0018_0000_0001, 0, 1, 1, 64'h2000_0020_0000_0001, 0, 1, 1);
    add(0, 64'hDEAD_BEEF_0000_0001, 0, 1, 0, 64'hDEAD_BEEF_0000_0001, 0, 1, 0);
    add(0, 64'hDEAD_BEEF_0000_0001, 0, 1, 1, 64'hDEAD_BEEF_0000_0001, 0, 1, 1);
    add(0, 64'h1122_3344_5566_7788, 1, 1, 0, 64'h1100_2200_3300_4400, 0, 1, 0);
    add(0, 64'h1122_3344_5566_7788, 1, 1, 1, 64'h1100_2200_3300_4400, 0, 1, 0);
    add(0, 64'h1122_3344_5566_7788, 1, 1, 0, 64'h5500_6600_7700_8800, 1, 1, 0);
    add(0, 64'h1122_3344_5566_7788, 1, 1, 1, 64'h5500_6600_7700_8800, 1, 1, 1);
    add(0, 64'h0000_000C_0000_0042, 0, 1, 1, 64'h0000_0010_0000_0042, 0, 1, 1);
    add(0, 64'h80FF_7F00_AAAA_BBBB, 1, 1, 1, 64'h8000_FF00_7F00_0000, 1, 1, 1);
    add(0, 64'h0000_0008_0000_0007, 1, 1, 1, 64'h0000_0008_0000_0007, 1, 1, 1);
    add(0, 64'h0000_0010_0000_1234, 0, 0, 1, 64'h0000_0018_0000_1234, 0, 0, 1);
    add(0, 64'h0000_0010_0000_1234, 0, 1, 1, 64'h0000_0018_0000_1234, 0, 1, 1);
    add(0, 64'h0102_0304_0506_0708, 1, 1, 1, 64'h0100_0200_0300_0400, 0, 1, 0);
    // reset lands while in LOW: header-format output must appear before the next edge
    add(1, 64'h0000_0010_0000_1234, 0, 1, 1, 64'h0000_0018_0000_1234, 0, 1, 1);
    add(0, 64'h0000_0010_0000_1234, 0, 1, 1, 64'h0000_0018_0000_1234, 0, 1, 1);
    add(0, 64'h0102_0304_0506_0708, 1, 1, 1, 64'h0100_0200_0300_0400, 0, 1, 0);
    add(0, 64'h0102_0304_0506_0708, 1, 1, 1, 64'h0500_0600_0700_0800, 1, 1, 1);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; i_tdata = vecs[i].d; i_tlast = vecs[i].l;
      i_tvalid = vecs[i].v; o_tready = vecs[i].ordy;
      #2;
      check($sformatf("v%0d_tdata", i), o_tdata, vecs[i].ed);
      check($sformatf("v%0d_tlast", i), 64'(o_tlast), 64'(vecs[i].el));
      check($sformatf("v%0d_tvalid", i), 64'(o_tvalid), 64'(vecs[i].ev));
      check($sformatf("v%0d_tready", i), 64'(i_tready), 64'(vecs[i].er));
      @(posedge clk); #1;
    end

    for (int p = 0; p < 1000; p++) begin
      ht = 1'($urandom_range(0, 1));
      pb = $urandom_range(0, 24);
      hb = ht ? 16 : 8;
      nw = (pb + 7) / 8;
      h = {$urandom, $urandom};
      h[61] = ht;
      h[47:32] = 16'(hb + pb);
      nl = 16'(2 * pb + hb);
      b.d = h; b.l = !ht && nw == 0; inq.push_back(b);
      e.d = {h[63:48], nl, h[31:0]}; e.l = b.l; expq.push_back(e);
      if (ht) begin
        b.d = {$urandom, $urandom}; b.l = nw == 0;
        inq.push_back(b); expq.push_back(b);
      end
      for (int k = 0; k < nw; k++) begin
        w = {$urandom, $urandom};
        b.d = w; b.l = k == nw - 1; inq.push_back(b);
        if (b.l && (pb % 8) != 0 && (pb % 8) <= 4) begin
          e.d = exp16(w[63:32]); e.l = 1'b1; expq.push_back(e);
        end else begin
          e.d = exp16(w[63:32]); e.l = 1'b0; expq.push_back(e);
          e.d = exp16(w[31:0]);  e.l = b.l;  expq.push_back(e);
        end
      end
    end

    rst = 1'b0; i_tvalid = 1'b0; in_hs = 1'b0; idx = 0; cyc = 0;
    while ((idx < inq.size() || expq.size() != 0) && cyc < 60000) begin
      if (in_hs) idx++;
      if (in_hs || !i_tvalid) begin
        if (idx < inq.size() && $urandom_range(0, 3) != 0) begin
          i_tvalid = 1'b1; i_tdata = inq[idx].d; i_tlast = inq[idx].l;
        end else begin
          i_tvalid = 1'b0;
        end
      end
      o_tready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (o_tvalid && o_tready) begin
        if (expq.size() == 0) begin
          check("rand_extra_beat", o_tdata, 64'hx);
        end else begin
          e = expq.pop_front();
          check("rand_tdata", o_tdata, e.d);
          check("rand_tlast", 64'(o_tlast), 64'(e.l));
        end
      end
      in_hs = i_tvalid && i_tready;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_remaining_out", 64'(expq.size()), 64'd0);
    check("rand_inputs_taken", 64'(idx), 64'(inq.size()));

`ifdef CHDR_8S_TO_16S_SID_OVERRIDE_EN
    i_tvalid = 1'b0; o_tready = 1'b0;
    set_stb = 1'b1; set_addr = 8'd0; set_data = 32'h0001_ABCD;
    @(posedge clk); #1;
    set_stb = 1'b0;
    i_tdata = 64'h0000_0010_1234_5678; i_tvalid = 1'b1;
    #2;
    check("sid_override_on", o_tdata, 64'h0000_0018_5678_ABCD);
    set_stb = 1'b1; set_data = 32'h0000_ABCD;
    @(posedge clk); #1;
    set_stb = 1'b0;
    #2;
    check("sid_override_off", o_tdata, 64'h0000_0018_1234_5678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
